scr1_ialu_arb: RTL and testbench

Sequencer/arbiter sharing one SCR1 integer ALU (IALU) between `N_REQ` requesters. It accepts one command at a time under round-robin arbitration and drives the IALU command and operand inputs from registers. It sequences multi-cycle RVM (mul/div) operations through the `ialu_rvm_cmd_vd`/`ialu_rvm_res_rdy` handshake. It returns captured results to the granted requester with a held valid/ready response. It sits between the EXU-side requesters and the IALU instance.

---
 rtl/scr1_ialu_arb_pkg.sv | 45 ++++
 rtl/scr1_ialu_arb_rr.sv | 41 ++++
 rtl/scr1_ialu_arb.sv | 117 +++++++++++
 tb/tb_scr1_ialu_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_ialu_arb_pkg.sv
// scr1_ialu_arb_pkg: IALU command set, arbiter FSM states and RVM command classification
package scr1_ialu_arb_pkg;

    localparam int SCR1_XLEN = 32;

    typedef enum logic [4:0] {
        SCR1_IALU_CMD_NONE,
        SCR1_IALU_CMD_AND,
        SCR1_IALU_CMD_OR,
        SCR1_IALU_CMD_XOR,
        SCR1_IALU_CMD_ADD,
        SCR1_IALU_CMD_SUB,
        SCR1_IALU_CMD_SUB_LT,
        SCR1_IALU_CMD_SUB_LTU,
        SCR1_IALU_CMD_SUB_EQ,
        SCR1_IALU_CMD_SUB_NE,
        SCR1_IALU_CMD_SUB_GE,
        SCR1_IALU_CMD_SUB_GEU,
        SCR1_IALU_CMD_SLL,
        SCR1_IALU_CMD_SRL,
        SCR1_IALU_CMD_SRA,
        SCR1_IALU_CMD_MUL,
        SCR1_IALU_CMD_MULHU,
        SCR1_IALU_CMD_MULHSU,
        SCR1_IALU_CMD_MULH,
        SCR1_IALU_CMD_DIV,
        SCR1_IALU_CMD_DIVU,
        SCR1_IALU_CMD_REM,
        SCR1_IALU_CMD_REMU
    } type_scr1_ialu_cmd_sel_e;

    localparam int SCR1_IALU_CMD_W = $bits(type_scr1_ialu_cmd_sel_e);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } type_scr1_ialu_arb_state_e;

    // mul/div/rem occupy the contiguous tail of the command enum
    function automatic logic is_rvm_cmd(input type_scr1_ialu_cmd_sel_e cmd);
        return cmd inside {[SCR1_IALU_CMD_MUL:SCR1_IALU_CMD_REMU]};
    endfunction

endpackage

// File: rtl/scr1_ialu_arb_rr.sv
// scr1_ialu_arb_rr: round-robin one-hot picker with a last-grant pointer, search starts at last+1
module scr1_ialu_arb_rr
    import scr1_ialu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_vd,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic [IW-1:0] k;

    // farthest candidate first so the nearest valid one after last overwrites it
    always_comb begin
        gnt  = '0;
        pick = last;
        k    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = IW'((int'(last) + i) % N_REQ);
            if (req_vd[k]) begin
                gnt  = N_REQ'(1) << k;
                pick = k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= IW'(N_REQ - 1);
        else if (advance)
            last <= pick;
    end

endmodule

// File: rtl/scr1_ialu_arb.sv
// scr1_ialu_arb: round-robin sequencer sharing one IALU among requesters
// SCR1_IALU_ARB_RVM_EN enables mul/div sequencing; otherwise RVM commands complete with rsp_err_o
module scr1_ialu_arb
    import scr1_ialu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_vd_i,
    output logic [N_REQ-1:0]                      req_rdy_o,
    input  logic [N_REQ-1:0][SCR1_IALU_CMD_W-1:0] req_cmd_i,
    input  logic [N_REQ-1:0][SCR1_XLEN-1:0]       req_main_op1_i,
    input  logic [N_REQ-1:0][SCR1_XLEN-1:0]       req_main_op2_i,
    input  logic [N_REQ-1:0][SCR1_XLEN-1:0]       req_addr_op1_i,
    input  logic [N_REQ-1:0][SCR1_XLEN-1:0]       req_addr_op2_i,
    output logic [N_REQ-1:0]                      rsp_vd_o,
    input  logic [N_REQ-1:0]                      rsp_rdy_i,
    output logic [SCR1_XLEN-1:0]                  rsp_main_res_o,
    output logic [SCR1_XLEN-1:0]                  rsp_addr_res_o,
    output logic                                  rsp_cmp_o,
    output logic                                  rsp_err_o,
    output logic                                  ialu_rvm_cmd_vd_o,
    output logic [SCR1_IALU_CMD_W-1:0]            ialu_cmd_o,
    output logic [SCR1_XLEN-1:0]                  ialu_main_op1_o,
    output logic [SCR1_XLEN-1:0]                  ialu_main_op2_o,
    output logic [SCR1_XLEN-1:0]                  ialu_addr_op1_o,
    output logic [SCR1_XLEN-1:0]                  ialu_addr_op2_o,
    input  logic [SCR1_XLEN-1:0]                  ialu_main_res_i,
    input  logic [SCR1_XLEN-1:0]                  ialu_addr_res_i,
    input  logic                                  ialu_cmp_res_i,
    input  logic                                  ialu_rvm_res_rdy_i
);

    localparam int IW = $clog2(N_REQ);
`ifdef SCR1_IALU_ARB_RVM_EN
    localparam bit RVM_EN = 1'b1;
`else
    localparam bit RVM_EN = 1'b0;
`endif

    type_scr1_ialu_arb_state_e state;
    logic [N_REQ-1:0]          gnt;
    logic [IW-1:0]             sel;
    logic [IW-1:0]             idx;
    logic                      transfer;
    logic                      rvm;
    logic                      bad;
    logic                      done;

    scr1_ialu_arb_rr #(.N_REQ(N_REQ)) i_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vd  (req_vd_i),
        .advance (transfer),
        .gnt     (gnt)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++)
            sel = gnt[i] ? IW'(i) : sel;
    end

    // grant is masked during reset so every output reads 0 while rst_n is low
    assign req_rdy_o = (rst_n && state == IDLE) ? gnt : '0;
    assign transfer  = |req_rdy_o;
    assign rvm       = is_rvm_cmd(type_scr1_ialu_cmd_sel_e'(ialu_cmd_o));
    assign bad       = rvm && !RVM_EN;
    assign done      = !(rvm && RVM_EN) || ialu_rvm_res_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= '0;
            ialu_cmd_o        <= '0;
            ialu_main_op1_o   <= '0;
            ialu_main_op2_o   <= '0;
            ialu_addr_op1_o   <= '0;
            ialu_addr_op2_o   <= '0;
            ialu_rvm_cmd_vd_o <= 1'b0;
            rsp_vd_o          <= '0;
            rsp_main_res_o    <= '0;
            rsp_addr_res_o    <= '0;
            rsp_cmp_o         <= 1'b0;
            rsp_err_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (transfer) begin
                    idx               <= sel;
                    ialu_cmd_o        <= req_cmd_i[sel];
                    ialu_main_op1_o   <= req_main_op1_i[sel];
                    ialu_main_op2_o   <= req_main_op2_i[sel];
                    ialu_addr_op1_o   <= req_addr_op1_i[sel];
                    ialu_addr_op2_o   <= req_addr_op2_i[sel];
                    ialu_rvm_cmd_vd_o <= RVM_EN && is_rvm_cmd(type_scr1_ialu_cmd_sel_e'(req_cmd_i[sel]));
                    state             <= EXEC;
                end
                EXEC: if (done) begin
                    rsp_main_res_o    <= bad ? '0 : ialu_main_res_i;
                    rsp_addr_res_o    <= bad ? '0 : ialu_addr_res_i;
                    rsp_cmp_o         <= !bad && ialu_cmp_res_i;
                    rsp_err_o         <= bad;
                    ialu_rvm_cmd_vd_o <= 1'b0;
                    rsp_vd_o          <= N_REQ'(1) << idx;
                    state             <= RESP;
                end
                RESP: if (rsp_rdy_i[idx]) begin
                    rsp_vd_o <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_ialu_arb.sv
// tb_scr1_ialu_arb: randomized self-checking bench with an IALU stub and a transaction-level reference model
module tb_scr1_ialu_arb;
    import scr1_ialu_arb_pkg::*;

    localparam int N  = 3;
    localparam int XL = SCR1_XLEN;
    localparam int CW = SCR1_IALU_CMD_W;
    localparam int OW = 2 * N + 6 * XL + 3 + CW;
`ifdef SCR1_IALU_ARB_RVM_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic                   clk, rst_n;
    logic [N-1:0]           req_vd_i, req_rdy_o, rsp_vd_o, rsp_rdy_i;
    logic [N-1:0][CW-1:0]   req_cmd_i;
    logic [N-1:0][XL-1:0]   req_main_op1_i, req_main_op2_i, req_addr_op1_i, req_addr_op2_i;
    logic [XL-1:0]          rsp_main_res_o, rsp_addr_res_o;
    logic                   rsp_cmp_o, rsp_err_o, ialu_rvm_cmd_vd_o;
    logic [CW-1:0]          ialu_cmd_o;
    logic [XL-1:0]          ialu_main_op1_o, ialu_main_op2_o, ialu_addr_op1_o, ialu_addr_op2_o;
    logic [XL-1:0]          ialu_main_res_i, ialu_addr_res_i;
    logic                   ialu_cmp_res_i, ialu_rvm_res_rdy_i;
    logic [255:0]           all_out;
    logic [4*XL-1:0]        ops_out;
    logic [N-1:0]           g;
    int                     checks = 0, errors = 0, last_m, vd_cnt = 0, vd_exp = 0;

    scr1_ialu_arb #(.N_REQ(N)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_vd_i           (req_vd_i),
        .req_rdy_o          (req_rdy_o),
        .req_cmd_i          (req_cmd_i),
        .req_main_op1_i     (req_main_op1_i),
        .req_main_op2_i     (req_main_op2_i),
        .req_addr_op1_i     (req_addr_op1_i),
        .req_addr_op2_i     (req_addr_op2_i),
        .rsp_vd_o           (rsp_vd_o),
        .rsp_rdy_i          (rsp_rdy_i),
        .rsp_main_res_o     (rsp_main_res_o),
        .rsp_addr_res_o     (rsp_addr_res_o),
        .rsp_cmp_o          (rsp_cmp_o),
        .rsp_err_o          (rsp_err_o),
        .ialu_rvm_cmd_vd_o  (ialu_rvm_cmd_vd_o),
        .ialu_cmd_o         (ialu_cmd_o),
        .ialu_main_op1_o    (ialu_main_op1_o),
        .ialu_main_op2_o    (ialu_main_op2_o),
        .ialu_addr_op1_o    (ialu_addr_op1_o),
        .ialu_addr_op2_o    (ialu_addr_op2_o),
        .ialu_main_res_i    (ialu_main_res_i),
        .ialu_addr_res_i    (ialu_addr_res_i),
        .ialu_cmp_res_i     (ialu_cmp_res_i),
        .ialu_rvm_res_rdy_i (ialu_rvm_res_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ops_out = {ialu_main_op1_o, ialu_main_op2_o, ialu_addr_op1_o, ialu_addr_op2_o};
    assign all_out = {{(256 - OW){1'b0}}, req_rdy_o, rsp_vd_o, rsp_main_res_o, rsp_addr_res_o,
                      rsp_cmp_o, rsp_err_o, ialu_rvm_cmd_vd_o, ialu_cmd_o, ops_out};

    function automatic logic is_rvm(input logic [CW-1:0] c);
        return c inside {SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_MULHSU, SCR1_IALU_CMD_MULH,
                         SCR1_IALU_CMD_DIV, SCR1_IALU_CMD_DIVU, SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU};
    endfunction

    function automatic logic [XL-1:0] alu_main(input logic [CW-1:0] c, input logic [XL-1:0] a, input logic [XL-1:0] b);
        case (c)
            SCR1_IALU_CMD_ADD:     return a + b;
            SCR1_IALU_CMD_AND:     return a & b;
            SCR1_IALU_CMD_OR:      return a | b;
            SCR1_IALU_CMD_XOR:     return a ^ b;
            SCR1_IALU_CMD_SUB,
            SCR1_IALU_CMD_SUB_LT,
            SCR1_IALU_CMD_SUB_LTU,
            SCR1_IALU_CMD_SUB_EQ:  return a - b;
            SCR1_IALU_CMD_MUL:     return a * b;
            SCR1_IALU_CMD_DIV:     return XL'($signed(a) / $signed(b));
            SCR1_IALU_CMD_DIVU:    return a / b;
            SCR1_IALU_CMD_REM:     return XL'($signed(a) % $signed(b));
            default:               return '0;
        endcase
    endfunction

    function automatic logic alu_cmp(input logic [CW-1:0] c, input logic [XL-1:0] a, input logic [XL-1:0] b);
        case (c)
            SCR1_IALU_CMD_SUB_LT:  return $signed(a) < $signed(b);
            SCR1_IALU_CMD_SUB_LTU: return a < b;
            SCR1_IALU_CMD_SUB_EQ:  return a == b;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic [CW-1:0] rand_cmd(input int i);
        case (i)
            0:       return SCR1_IALU_CMD_ADD;
            1:       return SCR1_IALU_CMD_SUB;
            2:       return SCR1_IALU_CMD_AND;
            3:       return SCR1_IALU_CMD_OR;
            4:       return SCR1_IALU_CMD_XOR;
            5:       return SCR1_IALU_CMD_SUB_LT;
            6:       return SCR1_IALU_CMD_SUB_LTU;
            7:       return SCR1_IALU_CMD_SUB_EQ;
            8:       return SCR1_IALU_CMD_MUL;
            9:       return SCR1_IALU_CMD_DIV;
            10:      return SCR1_IALU_CMD_DIVU;
            default: return SCR1_IALU_CMD_REM;
        endcase
    endfunction

    // reference arbitration: first valid requester after the last one served
    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++)
            if (mask[(last_m + i) % N]) return (last_m + i) % N;
        return 0;
    endfunction

    // IALU stub: RVM results read as garbage until res_rdy is raised
    always_comb begin
        ialu_main_res_i = alu_main(ialu_cmd_o, ialu_main_op1_o, ialu_main_op2_o);
        ialu_addr_res_i = ialu_addr_op1_o + ialu_addr_op2_o;
        ialu_cmp_res_i  = alu_cmp(ialu_cmd_o, ialu_main_op1_o, ialu_main_op2_o);
        if (is_rvm(ialu_cmd_o) && !ialu_rvm_res_rdy_i) begin
            ialu_main_res_i = ~ialu_main_res_i;
            ialu_addr_res_i = ~ialu_addr_res_i;
            ialu_cmp_res_i  = ~ialu_cmp_res_i;
        end
    end

    always @(negedge clk) if (ialu_rvm_cmd_vd_o) vd_cnt <= vd_cnt + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_all();
        for (int r = 0; r < N; r++) begin
            logic [CW-1:0] c;
            c = rand_cmd(int'($urandom_range(0, 11)));
            req_cmd_i[r]      = c;
            req_main_op1_i[r] = $urandom;
            req_main_op2_i[r] = is_rvm(c) ? XL'($urandom_range(1, 1000)) :
                                ($urandom_range(0, 3) == 0) ? req_main_op1_i[r] : XL'($urandom);
            req_addr_op1_i[r] = $urandom;
            req_addr_op2_i[r] = $urandom;
        end
    endtask

    task automatic txn(input logic [N-1:0] mask, input int lat, input int bp, output logic [N-1:0] gnt_seen);
        int              w, k;
        logic [CW-1:0]   c;
        logic [4*XL-1:0] ops;
        logic [N-1:0]    oh;
        logic            rv, ec, ee;
        logic [XL-1:0]   em, ea;
        req_vd_i = mask;
        #1;
        w        = rr_pick(mask);
        oh       = N'(1) << w;
        gnt_seen = req_rdy_o;
        check("grant", 256'(req_rdy_o), 256'(oh));
        c   = req_cmd_i[w];
        ops = {req_main_op1_i[w], req_main_op2_i[w], req_addr_op1_i[w], req_addr_op2_i[w]};
        rv  = is_rvm(c);
        ee  = rv && !EN;
        em  = ee ? '0 : alu_main(c, ops[4*XL-1 -: XL], ops[3*XL-1 -: XL]);
        ea  = ee ? '0 : ops[2*XL-1 -: XL] + ops[XL-1:0];
        ec  = ee ? 1'b0 : alu_cmp(c, ops[4*XL-1 -: XL], ops[3*XL-1 -: XL]);
        k   = (rv && EN) ? lat : 1;
        vd_exp += (rv && EN) ? lat : 0;
        last_m = w;
        for (int i = 1; i <= k; i++) begin
            step();
            req_vd_i = '1;
            rand_all();
            ialu_rvm_res_rdy_i = (i == k) ? ((rv && EN) ? 1'b1 : 1'($urandom)) : 1'b0;
            #1;
            check("exec_no_grant", 256'(req_rdy_o), 256'(0));
            check("exec_no_rsp", 256'(rsp_vd_o), 256'(0));
            check("exec_cmd", 256'(ialu_cmd_o), 256'(c));
            check("exec_ops", 256'(ops_out), 256'(ops));
            check("exec_rvm_vd", 256'(ialu_rvm_cmd_vd_o), 256'(rv && EN));
        end
        step();
        ialu_rvm_res_rdy_i = 1'b0;
        check("rsp_rvm_vd_off", 256'(ialu_rvm_cmd_vd_o), 256'(0));
        for (int b = 0; b <= bp; b++) begin
            rsp_rdy_i = (b == bp) ? (oh | N'($urandom)) : (~oh & N'($urandom));
            #1;
            check("rsp_hold", 256'({rsp_vd_o, rsp_main_res_o, rsp_addr_res_o, rsp_cmp_o, rsp_err_o}),
                  256'({oh, em, ea, ec, ee}));
            check("rsp_no_grant", 256'(req_rdy_o), 256'(0));
            step();
        end
        rsp_rdy_i = '0;
        req_vd_i  = '0;
        #1;
        check("rsp_done", 256'(rsp_vd_o), 256'(0));
    endtask

    task automatic reset_mid();
        int w;
        for (int r = 0; r < N; r++) begin
            req_cmd_i[r]      = SCR1_IALU_CMD_DIV;
            req_main_op2_i[r] = 3;
        end
        req_vd_i = '1;
        #1;
        w = rr_pick('1);
        check("rm_grant", 256'(req_rdy_o), 256'(N'(1) << w));
        step();
        #1;
        check("rm_exec_vd", 256'(ialu_rvm_cmd_vd_o), 256'(EN));
        rst_n = 1'b0;
        #1;
        check("rm_zero", all_out, 256'(0));
        step();
        check("rm_zero_hold", all_out, 256'(0));
        rst_n    = 1'b1;
        last_m   = N - 1;
        req_vd_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 required");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_vd_i = '1;
        rsp_rdy_i = '0;
        ialu_rvm_res_rdy_i = 1'b0;
        last_m = N - 1;
        rand_all();
        step();
        step();
        check("reset_outs", all_out, 256'(0));
        rst_n = 1'b1;
        req_vd_i = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            rand_all();
            txn(N'(3), int'($urandom_range(1, 4)), 0, g);
            check("fair_order", 256'(g), 256'(N'(1) << (i % 2)));
        end
        rand_all();
        req_cmd_i[0] = SCR1_IALU_CMD_ADD;
        req_main_op1_i[0] = 5;
        req_main_op2_i[0] = 7;
        txn(N'(1), 1, 0, g);
        rand_all();
        req_cmd_i[0] = SCR1_IALU_CMD_DIV;
        req_main_op1_i[0] = 100;
        req_main_op2_i[0] = 7;
        txn(N'(1), 5, 0, g);
        rand_all();
        txn('1, 2, 3, g);
        reset_mid();
        rand_all();
        txn('1, 1, 0, g);
        check("rm_first_grant", 256'(g), 256'(1));
        for (int i = 0; i < 40; i++) begin
            rand_all();
            txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), g);
        end
        step();
        check("rvm_vd_cycles", 256'(vd_cnt), 256'(vd_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
